// File: rtl/axicb_scfifo_pf.sv
`default_nettype none
// ============================================================================
// axicb_scfifo_pf : single-clock show-ahead FIFO, optional registered prefetch
// Rev 1.0
// ============================================================================
module axicb_scfifo_pf #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int FFD_EN        = 0,
    parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [LW-1:0]         c_depth   = LW'(DEPTH);
    localparam logic [LW-1:0]         c_afull   = LW'(AFULL_THRESH);
    localparam logic [LW-1:0]         c_aempty  = LW'(AEMPTY_THRESH);
    localparam logic [LW-1:0]         c_lvl_one = LW'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_adv;
    logic [LW-1:0]         w_level_nxt;

    // srst wins over both handshakes in its cycle
    assign w_push = in_valid && !r_full && !srst;
    assign w_pop  = out_valid && out_ready && !srst;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_lvl_one;
            2'b01:   w_level_nxt = r_level - c_lvl_one;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == c_depth);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (w_level_nxt >= c_afull);
            r_aempty <= (w_level_nxt <= c_aempty);
        end
    end

    generate
        if (FFD_EN != 0) begin : g_prefetch
            logic                  r_out_valid;
            logic [DATA_WIDTH-1:0] r_out_data;
            logic                  w_ram_avail;
            logic                  w_load;

            // level includes the output register, so RAM holds level - out_valid words
            assign w_ram_avail = (r_level != {{ADDR_WIDTH{1'b0}}, r_out_valid});
            assign w_load      = w_ram_avail && (!r_out_valid || out_ready) && !srst;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else if (srst) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else if (w_load) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= mem[r_rd_ptr];
                end else if (w_pop) begin
                    r_out_valid <= 1'b0;
                end
            end

            assign out_valid = r_out_valid;
            assign out_data  = r_out_data;
            assign w_rd_adv  = w_load;
        end else begin : g_comb_read
            assign out_valid = !r_empty;
            assign out_data  = mem[r_rd_ptr];
            assign w_rd_adv  = w_pop;
        end
    endgenerate

    assign in_ready = !r_full;
    assign full     = r_full;
    assign empty    = r_empty;
    assign afull    = r_afull;
    assign aempty   = r_aempty;
    assign level    = r_level;

endmodule
`default_nettype wire
